// File: rtl/outport_bcd_display.sv
// Converts each outport write to packed BCD (double-dabble) and drives active-low 7-seg digits.
// Latency DATA_WIDTH+1 cycles write-to-valid; no backpressure, one-deep pending slot where the latest write wins.
module outport_bcd_display #(
    parameter int DATA_WIDTH    = 16,
    parameter int DIGITS        = 5,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_write,
    input  logic [31:0]           in_data,
    output logic                  out_busy,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [7*DIGITS-1:0]   out_segments
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [4*DIGITS-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [DATA_WIDTH-1:0]  pend_dat_q, pend_dat_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic [7*DIGITS-1:0]    seg_q, seg_d;
    logic [7*DIGITS-1:0]    seg_rst;
    logic [4*DIGITS-1:0]    adj;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Walk from the most significant digit down; blanking stops at the first nonzero digit.
    function automatic logic [7*DIGITS-1:0] decode(input logic [4*DIGITS-1:0] bcd);
        logic lead;
        lead   = 1'b1;
        decode = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0)
                lead = 1'b0;
            if ((BLANK_LEADING != 0) && lead && (i > 0))
                decode[7*i +: 7] = 7'h7F;
            else
                decode[7*i +: 7] = seg7(bcd[4*i +: 4]);
        end
    endfunction

    assign seg_rst = decode('0);

    generate
        if (DATA_WIDTH < 32) begin : g_hi
            logic unused_in_hi;
            assign unused_in_hi = ^in_data[31:DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        valid_d    = 1'b0;
        bcd_d      = bcd_q;
        seg_d      = seg_q;
        adj        = scratch_q;

        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (in_write) begin
                    shift_d   = in_data[DATA_WIDTH-1:0];
                    scratch_d = '0;
                    count_d   = CW'(DATA_WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1))
                    state_d = DONE;
                if (in_write) begin
                    pend_vld_d = 1'b1;
                    pend_dat_d = in_data[DATA_WIDTH-1:0];
                end
            end
            DONE: begin
                valid_d = 1'b1;
                bcd_d   = scratch_q;
                seg_d   = decode(scratch_q);
                // A write landing in this very cycle is newer than anything pending.
                if (in_write || pend_vld_q) begin
                    shift_d    = in_write ? in_data[DATA_WIDTH-1:0] : pend_dat_q;
                    scratch_d  = '0;
                    count_d    = CW'(DATA_WIDTH);
                    pend_vld_d = 1'b0;
                    state_d    = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) | pend_vld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
            seg_q      <= seg_rst;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            bcd_q      <= bcd_d;
            seg_q      <= seg_d;
        end
    end

    assign out_busy     = busy_q;
    assign out_valid    = valid_q;
    assign out_bcd      = bcd_q;
    assign out_segments = seg_q;

endmodule

// File: tb/tb_outport_bcd_display.sv
// Directed bench for outport_bcd_display: expected results queued at stimulus time, checked by a monitor on out_valid.
module tb_outport_bcd_display;

    logic        clk;
    logic        reset;
    logic        in_write;
    logic [31:0] in_data;
    logic        out_busy;
    logic        out_valid;
    logic [19:0] out_bcd;
    logic [34:0] out_segments;

    typedef struct {
        logic [19:0] bcd;
        logic [34:0] seg;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    localparam logic [34:0] SEG_RST = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};

    outport_bcd_display #(.DATA_WIDTH(16), .DIGITS(5), .BLANK_LEADING(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_write     (in_write),
        .in_data      (in_data),
        .out_busy     (out_busy),
        .out_valid    (out_valid),
        .out_bcd      (out_bcd),
        .out_segments (out_segments)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [19:0] b, input logic [34:0] s, input int c);
        exp_t e;
        e.bcd = b;
        e.seg = s;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Drive a write for the next edge; returns the cycle index of the sampling edge.
    task automatic do_write(input logic [31:0] d, output int e0);
        in_write = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_write = 1'b0;
        e0 = cyc;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bcd"},   64'(out_bcd),      64'(20'h00000));
        chk({tag, "_seg"},   64'(out_segments), 64'(SEG_RST));
        chk({tag, "_busy"},  64'(out_busy),     64'(1'b0));
        chk({tag, "_valid"}, 64'(out_valid),    64'(1'b0));
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got bcd %0h expected no result (cycle %0d)", out_bcd, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_bcd",   64'(out_bcd),      64'(e.bcd));
                chk("result_seg",   64'(out_segments), 64'(e.seg));
                chk("result_cycle", 64'(cyc),          64'(e.cyc));
            end
        end
    end

    initial begin
        int e0;
        int lows;
        reset    = 1'b1;
        in_write = 1'b0;
        in_data  = '0;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // 2: 0x88 -> 136
        do_write(32'h0000_0088, e0);
        push(20'h00136, {7'h7F, 7'h7F, 7'h79, 7'h30, 7'h02}, e0 + 17);
        chk("busy_after_write", 64'(out_busy), 64'(1'b1));
        repeat (20) @(negedge clk);
        chk("busy_idle_t2", 64'(out_busy), 64'(1'b0));

        // 3: upper bits ignored, 0xFFFF -> 65535
        do_write(32'h1234_FFFF, e0);
        push(20'h65535, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}, e0 + 17);
        repeat (20) @(negedge clk);

        // 4: 5, then 9 and 7 while busy; 9 is overwritten
        do_write(32'd5, e0);
        push(20'h00005, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12}, e0 + 17);
        push(20'h00007, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}, e0 + 34);
        lows = 0;
        for (int k = 1; k <= 34; k++) begin
            in_write = (k == 3) || (k == 6);
            in_data  = (k == 3) ? 32'd9 : 32'd7;
            @(negedge clk);
            if (k < 34 && out_busy !== 1'b1) lows++;
        end
        in_write = 1'b0;
        chk("busy_held_t4", 64'(lows), 64'(0));
        chk("busy_release_t4", 64'(out_busy), 64'(1'b0));
        repeat (5) @(negedge clk);

        // 5: reset mid-conversion aborts it
        do_write(32'd123, e0);
        for (int k = 1; k <= 9; k++) begin
            reset = (k >= 8);
            @(negedge clk);
        end
        reset = 1'b0;
        chk_reset_vals("abort");
        repeat (30) @(negedge clk);
        chk("abort_busy_later", 64'(out_busy), 64'(1'b0));

        // 6: write landing in the DONE cycle restarts immediately
        do_write(32'd42, e0);
        push(20'h00042, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, e0 + 17);
        push(20'h00008, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00}, e0 + 34);
        for (int k = 1; k <= 17; k++) begin
            in_write = (k == 17);
            in_data  = 32'd8;
            @(negedge clk);
        end
        in_write = 1'b0;
        chk("busy_restart_t6", 64'(out_busy), 64'(1'b1));
        repeat (20) @(negedge clk);
        chk("busy_idle_t6", 64'(out_busy), 64'(1'b0));

        chk("results_outstanding", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
